// File: rtl/shift_pkg.sv
// Shared types and constants for the serial transmitter slice.
// S_PARITY is only reachable when SHIFT_TX_PARITY_EN is defined.
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_serial_tx_counter.sv
// Loadable down-counter for the transmitter; o_tc flags the last data bit.
// Load has priority over decrement; the count saturates at zero.
module shift_tx_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/shift_serial_tx.sv
// Parallel-in/serial-out transmitter with per-word bit order and frame/done strobes.
// Optional even-parity trailer bit enabled by defining SHIFT_TX_PARITY_EN.
module shift_serial_tx
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data,
    input  logic             Data_Valid,
    output logic             Data_Ready,
    input  logic             Dir,
    output logic             Serial_Out,
    output logic             Frame,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic             r_dir;
    logic             w_dir_next;
    logic             r_serial;
    logic             w_serial_next;
`ifdef SHIFT_TX_PARITY_EN
    logic             r_parity;
    logic             w_parity_next;
`endif

    logic w_tc;
    logic w_last;
    logic w_ready;
    logic w_accept;
    logic w_dec;

    // The final-bit cycle is the only non-idle cycle in which a new word may be taken.
`ifdef SHIFT_TX_PARITY_EN
    assign w_last = (r_state == S_PARITY);
`else
    assign w_last = (r_state == S_SHIFT) && w_tc;
`endif
    assign w_ready  = (r_state == S_IDLE) || w_last;
    assign w_accept = Data_Valid && w_ready;
    assign w_dec    = (r_state == S_SHIFT) && !w_tc;

    shift_tx_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_load       (w_accept),
        .i_load_value (CNT_W'(WIDTH - 1)),
        .i_dec        (w_dec),
        .o_tc         (w_tc)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_dir    <= DIR_LSB_FIRST;
            r_serial <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_dir    <= w_dir_next;
            r_serial <= w_serial_next;
`ifdef SHIFT_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    // The first bit is peeled off at load time so Serial_Out stays a plain register.
    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_dir_next    = r_dir;
        w_serial_next = r_serial;
`ifdef SHIFT_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        if (w_accept) begin
            w_state_next = S_SHIFT;
            w_dir_next   = Dir;
`ifdef SHIFT_TX_PARITY_EN
            w_parity_next = ^Data;
`endif
            if (Dir == DIR_MSB_FIRST) begin
                {w_serial_next, w_shift_next} = {Data, 1'b0};
            end else begin
                {w_shift_next, w_serial_next} = {1'b0, Data};
            end
        end else begin
            unique case (r_state)
                S_SHIFT: begin
                    if (w_tc) begin
`ifdef SHIFT_TX_PARITY_EN
                        w_state_next  = S_PARITY;
                        w_serial_next = r_parity;
`else
                        w_state_next  = S_IDLE;
                        w_serial_next = 1'b0;
`endif
                    end else if (r_dir == DIR_LSB_FIRST) begin
                        {w_shift_next, w_serial_next} = {1'b0, r_shift};
                    end else begin
                        {w_serial_next, w_shift_next} = {r_shift, 1'b0};
                    end
                end
                S_PARITY: begin
                    w_state_next  = S_IDLE;
                    w_serial_next = 1'b0;
                end
                default: begin
                    w_state_next  = S_IDLE;
                    w_serial_next = 1'b0;
                end
            endcase
        end
    end

    assign Data_Ready = w_ready;
    assign Serial_Out = r_serial;
    assign Frame      = (r_state != S_IDLE);
    assign Done       = w_last;

endmodule
